// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Video output stage in the pixel clock domain. Free-running raster counters
//   produce panel timing. One pixel is popped from a show-ahead FIFO per active
//   cycle, and RGB is driven aligned with BLANK. Underflow is flagged, and a
//   frame-start pulse lets the upstream reader restart.
// Ports
//   pixel_clk, pixel_rst_n   clock, asynchronous active-low reset
//   fifo_rdata, fifo_empty   show-ahead FIFO head {R,G,B} and empty flag
//   fifo_rd                  combinational pop strobe (one per active pixel)
//   frame_start              registered one-cycle pulse at counter wrap to (0,0)
//   underflow                sticky per-frame FIFO underflow flag
//   VGA_HS/VS/BLANK/R/G/B    registered panel outputs, one cycle after counters
module vga_timing_gen #(
    parameter int unsigned HDISP  = 800,
    parameter int unsigned HFP    = 40,
    parameter int unsigned HPULSE = 48,
    parameter int unsigned HBP    = 40,
    parameter int unsigned VDISP  = 480,
    parameter int unsigned VFP    = 13,
    parameter int unsigned VPULSE = 3,
    parameter int unsigned VBP    = 29
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst_n,
    input  logic [23:0] fifo_rdata,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    output logic        frame_start,
    output logic        underflow,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
);

    localparam int unsigned HTOTAL = HDISP + HFP + HPULSE + HBP;
    localparam int unsigned VTOTAL = VDISP + VFP + VPULSE + VBP;
    localparam int unsigned HW     = $clog2(HTOTAL);
    localparam int unsigned VW     = $clog2(VTOTAL);

    localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(HDISP);
    localparam logic [HW-1:0] H_SYNC_S = HW'(HDISP + HFP);
    localparam logic [HW-1:0] H_SYNC_E = HW'(HDISP + HFP + HPULSE);
    localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(VDISP);
    localparam logic [VW-1:0] V_SYNC_S = VW'(VDISP + VFP);
    localparam logic [VW-1:0] V_SYNC_E = VW'(VDISP + VFP + VPULSE);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          blank_q, blank_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          frame_start_q, frame_start_d;
    logic          underflow_q, underflow_d;

    logic active_c;
    logic h_wrap_c;
    logic uf_now_c;

    // Raster decode and next-state logic
    always_comb begin
        hcnt_d        = hcnt_q + HW'(1);
        vcnt_d        = vcnt_q;
        active_c      = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        h_wrap_c      = (hcnt_q == H_LAST);
        // Gated by reset: counters sit at (0,0), which is an active pixel
        fifo_rd       = active_c && !fifo_empty && pixel_rst_n;
        uf_now_c      = active_c && fifo_empty;

        if (h_wrap_c) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
        end

        hs_d          = !((hcnt_q >= H_SYNC_S) && (hcnt_q < H_SYNC_E));
        vs_d          = !((vcnt_q >= V_SYNC_S) && (vcnt_q < V_SYNC_E));
        blank_d       = active_c;
        rgb_d         = fifo_rd ? fifo_rdata : 24'h000000;
        frame_start_d = h_wrap_c && (vcnt_q == V_LAST);
        // Cleared on the frame_start cycle; a fresh underflow in that cycle still sets it
        underflow_d   = frame_start_q ? uf_now_c : (underflow_q | uf_now_c);
    end

    // State and output registers
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
            rgb_q         <= 24'h000000;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK   = blank_q;
    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen on an 8x6 raster (4x3 active).
// A reference raster model pushes the expected outputs per cycle into a queue.
// A negedge monitor pops the queue and compares against the DUT.
module tb_vga_timing_gen;

    localparam int HDISP_T = 4, HFP_T = 1, HPULSE_T = 2, HBP_T = 1;
    localparam int VDISP_T = 3, VFP_T = 1, VPULSE_T = 1, VBP_T = 1;
    localparam int HT = HDISP_T + HFP_T + HPULSE_T + HBP_T;
    localparam int VT = VDISP_T + VFP_T + VPULSE_T + VBP_T;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] fifo_rdata;
    logic        fifo_empty;
    logic        fifo_rd;
    logic        frame_start;
    logic        underflow;
    logic        vga_hs, vga_vs, vga_blank;
    logic [7:0]  vga_r, vga_g, vga_b;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .HDISP(HDISP_T), .HFP(HFP_T), .HPULSE(HPULSE_T), .HBP(HBP_T),
        .VDISP(VDISP_T), .VFP(VFP_T), .VPULSE(VPULSE_T), .VBP(VBP_T)
    ) dut (
        .pixel_clk  (clk),
        .pixel_rst_n(rst_n),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .frame_start(frame_start),
        .underflow  (underflow),
        .VGA_HS     (vga_hs),
        .VGA_VS     (vga_vs),
        .VGA_BLANK  (vga_blank),
        .VGA_R      (vga_r),
        .VGA_G      (vga_g),
        .VGA_B      (vga_b)
    );

    typedef struct packed {
        logic        rd;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        fs;
        logic        uf;
        logic [23:0] rgb;
    } exp_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    exp_t  sb_q[$];
    exp_t  prev, cur;
    bit    have_prev = 0;
    bit    mon_en    = 0;

    // Reference model state: counters as seen by the DUT in the current cycle
    int          m_h, m_v;
    bit          m_fs, m_uf;
    logic [23:0] d;

    // Scoreboard monitor: fifo_rd for this cycle, registered outputs from the last one
    always @(negedge clk) begin
        if (mon_en) begin
            if (have_prev) begin
                n_checks++;
                if (vga_hs !== prev.hs) begin
                    n_fail++; $display("FAIL sb_hs t=%0t got %b exp %b", $time, vga_hs, prev.hs);
                end
                n_checks++;
                if (vga_vs !== prev.vs) begin
                    n_fail++; $display("FAIL sb_vs t=%0t got %b exp %b", $time, vga_vs, prev.vs);
                end
                n_checks++;
                if (vga_blank !== prev.blank) begin
                    n_fail++; $display("FAIL sb_blank t=%0t got %b exp %b", $time, vga_blank, prev.blank);
                end
                n_checks++;
                if ({vga_r, vga_g, vga_b} !== prev.rgb) begin
                    n_fail++; $display("FAIL sb_rgb t=%0t got %h exp %h", $time, {vga_r, vga_g, vga_b}, prev.rgb);
                end
                n_checks++;
                if (frame_start !== prev.fs) begin
                    n_fail++; $display("FAIL sb_frame_start t=%0t got %b exp %b", $time, frame_start, prev.fs);
                end
                n_checks++;
                if (underflow !== prev.uf) begin
                    n_fail++; $display("FAIL sb_underflow t=%0t got %b exp %b", $time, underflow, prev.uf);
                end
                have_prev = 0;
            end
            if (sb_q.size() > 0) begin
                cur = sb_q.pop_front();
                n_checks++;
                if (fifo_rd !== cur.rd) begin
                    n_fail++; $display("FAIL sb_fifo_rd t=%0t got %b exp %b", $time, fifo_rd, cur.rd);
                end
                prev      = cur;
                have_prev = 1;
            end
        end
    end

    // One pixel cycle: drive FIFO, push the model's expectation, advance the clock
    task automatic cycle(input bit empty, output bit o_rd, output bit o_fs,
                         output bit o_uf, output bit o_hs, output bit o_vs);
        exp_t e;
        bit   act, unow;
        act        = (m_h < HDISP_T) && (m_v < VDISP_T);
        unow       = act && empty;
        fifo_empty = empty;
        fifo_rdata = empty ? 24'hBAD0BA : d;
        e.rd       = act && !empty;
        e.hs       = !((m_h >= HDISP_T + HFP_T) && (m_h < HDISP_T + HFP_T + HPULSE_T));
        e.vs       = !((m_v >= VDISP_T + VFP_T) && (m_v < VDISP_T + VFP_T + VPULSE_T));
        e.blank    = act;
        e.rgb      = e.rd ? d : 24'h000000;
        e.fs       = (m_h == HT - 1) && (m_v == VT - 1);
        e.uf       = m_fs ? unow : (m_uf | unow);
        sb_q.push_back(e);
        #1 o_rd = fifo_rd;
        @(posedge clk);
        #1;
        o_fs = frame_start;
        o_uf = underflow;
        o_hs = vga_hs;
        o_vs = vga_vs;
        if (e.rd) d = d + 24'd1;
        m_fs = e.fs;
        m_uf = e.uf;
        if (m_h == HT - 1) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
            m_h = m_h + 1;
        end
    endtask

    // One full frame from (0,0); FIFO empty only at pixel (eh,ev)
    task automatic run_frame(input int eh, input int ev, output int pops, output int fs_cnt,
                             output int fs_idx, output int hs_low, output int vs_low,
                             output int uf_ones, output bit uf_first);
        bit rd, fs, uf, hs, vs;
        pops = 0; fs_cnt = 0; fs_idx = -1; hs_low = 0; vs_low = 0; uf_ones = 0; uf_first = 0;
        for (int i = 0; i < FRAME; i++) begin
            cycle((m_h == eh) && (m_v == ev), rd, fs, uf, hs, vs);
            pops += int'(rd);
            if (fs) begin fs_cnt++; fs_idx = i; end
            hs_low += int'(!hs);
            vs_low += int'(!vs);
            uf_ones += int'(uf);
            if (i == 0) uf_first = uf;
        end
    endtask

    task automatic release_reset();
        rst_n     = 1'b1;
        m_h = 0; m_v = 0; m_fs = 0; m_uf = 0;
        sb_q.delete();
        prev      = '{rd: 1'b0, hs: 1'b1, vs: 1'b1, blank: 1'b0, fs: 1'b0, uf: 1'b0, rgb: 24'h0};
        have_prev = 1;
        mon_en    = 1;
    endtask

    task automatic test_reset();
        logic [29:0] got;
        rst_n      = 1'b0;
        fifo_empty = 1'b0;
        fifo_rdata = 24'h123456;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = {vga_hs, vga_vs, vga_blank, frame_start, underflow, fifo_rd, vga_r, vga_g, vga_b};
        n_checks++;
        if (got !== {6'b110000, 24'h0}) begin
            n_fail++; $display("FAIL reset_values got %h exp %h", got, {6'b110000, 24'h0});
        end
        @(posedge clk);
        #1 release_reset();
    endtask

    task automatic test_timing();
        int pops, fs_cnt, fs_idx, hs_low, vs_low, uf_ones;
        bit uf_first;
        for (int f = 0; f < 2; f++) begin
            run_frame(-1, -1, pops, fs_cnt, fs_idx, hs_low, vs_low, uf_ones, uf_first);
            n_checks++;
            if (pops !== 12) begin n_fail++; $display("FAIL timing_pops f=%0d got %0d exp 12", f, pops); end
            n_checks++;
            if (fs_cnt !== 1) begin n_fail++; $display("FAIL timing_fs_count f=%0d got %0d exp 1", f, fs_cnt); end
            n_checks++;
            if (fs_idx !== FRAME - 1) begin
                n_fail++; $display("FAIL timing_fs_pos f=%0d got %0d exp %0d", f, fs_idx, FRAME - 1);
            end
            n_checks++;
            if (hs_low !== 12) begin n_fail++; $display("FAIL timing_hs_low f=%0d got %0d exp 12", f, hs_low); end
            n_checks++;
            if (vs_low !== 8) begin n_fail++; $display("FAIL timing_vs_low f=%0d got %0d exp 8", f, vs_low); end
            n_checks++;
            if (uf_ones !== 0) begin n_fail++; $display("FAIL timing_no_uf f=%0d got %0d exp 0", f, uf_ones); end
        end
    endtask

    task automatic test_underflow();
        int pops, fs_cnt, fs_idx, hs_low, vs_low, uf_ones;
        bit uf_first;
        run_frame(2, 1, pops, fs_cnt, fs_idx, hs_low, vs_low, uf_ones, uf_first);
        n_checks++;
        if (pops !== 11) begin n_fail++; $display("FAIL uf_pops got %0d exp 11", pops); end
        n_checks++;
        if (uf_ones !== 38) begin n_fail++; $display("FAIL uf_sticky_len got %0d exp 38", uf_ones); end
        run_frame(-1, -1, pops, fs_cnt, fs_idx, hs_low, vs_low, uf_ones, uf_first);
        n_checks++;
        if (uf_first !== 1'b0) begin n_fail++; $display("FAIL uf_clear got %b exp 0", uf_first); end
        n_checks++;
        if (uf_ones !== 0) begin n_fail++; $display("FAIL uf_clean_frame got %0d exp 0", uf_ones); end
        n_checks++;
        if (pops !== 12) begin n_fail++; $display("FAIL uf_recover_pops got %0d exp 12", pops); end
    endtask

    // Underflow on the last active pixel, then again on the frame_start cycle
    task automatic test_back_to_back();
        int pops, fs_cnt, fs_idx, hs_low, vs_low, uf_ones;
        bit uf_first;
        run_frame(3, 2, pops, fs_cnt, fs_idx, hs_low, vs_low, uf_ones, uf_first);
        n_checks++;
        if (uf_ones !== 29) begin n_fail++; $display("FAIL b2b_last_pixel got %0d exp 29", uf_ones); end
        run_frame(0, 0, pops, fs_cnt, fs_idx, hs_low, vs_low, uf_ones, uf_first);
        n_checks++;
        if (uf_first !== 1'b1) begin n_fail++; $display("FAIL b2b_set_wins got %b exp 1", uf_first); end
        n_checks++;
        if (uf_ones !== 48) begin n_fail++; $display("FAIL b2b_hold got %0d exp 48", uf_ones); end
        n_checks++;
        if (pops !== 11) begin n_fail++; $display("FAIL b2b_pops got %0d exp 11", pops); end
        run_frame(-1, -1, pops, fs_cnt, fs_idx, hs_low, vs_low, uf_ones, uf_first);
        n_checks++;
        if (uf_first !== 1'b0) begin n_fail++; $display("FAIL b2b_clear got %b exp 0", uf_first); end
    endtask

    task automatic test_reset_mid();
        int pops, fs_cnt, fs_idx, hs_low, vs_low, uf_ones;
        bit uf_first, rd, fs, uf, hs, vs;
        logic [29:0] got;
        uf = 1'b0;
        // Advance to pixel (3,2) with an underflow at (1,0) so the flag is set
        for (int i = 0; i < 2 * HT + 3; i++) cycle((m_h == 1) && (m_v == 0), rd, fs, uf, hs, vs);
        n_checks++;
        if (uf !== 1'b1) begin n_fail++; $display("FAIL rstmid_uf_pre got %b exp 1", uf); end
        mon_en     = 0;
        have_prev  = 0;
        fifo_empty = 1'b0;
        fifo_rdata = 24'h654321;
        rst_n      = 1'b0;
        #1;
        got = {vga_hs, vga_vs, vga_blank, frame_start, underflow, fifo_rd, vga_r, vga_g, vga_b};
        n_checks++;
        if (got !== {6'b110000, 24'h0}) begin
            n_fail++; $display("FAIL rstmid_async got %h exp %h", got, {6'b110000, 24'h0});
        end
        repeat (3) begin @(posedge clk); #1; end
        got = {vga_hs, vga_vs, vga_blank, frame_start, underflow, fifo_rd, vga_r, vga_g, vga_b};
        n_checks++;
        if (got !== {6'b110000, 24'h0}) begin
            n_fail++; $display("FAIL rstmid_hold got %h exp %h", got, {6'b110000, 24'h0});
        end
        release_reset();
        run_frame(-1, -1, pops, fs_cnt, fs_idx, hs_low, vs_low, uf_ones, uf_first);
        n_checks++;
        if (pops !== 12) begin n_fail++; $display("FAIL rstmid_pops got %0d exp 12", pops); end
        n_checks++;
        if (fs_idx !== FRAME - 1 || fs_cnt !== 1) begin
            n_fail++; $display("FAIL rstmid_fs got idx %0d cnt %0d exp idx %0d cnt 1", fs_idx, fs_cnt, FRAME - 1);
        end
        n_checks++;
        if (uf_ones !== 0) begin n_fail++; $display("FAIL rstmid_uf got %0d exp 0", uf_ones); end
    endtask

    initial begin
        rst_n      = 1'b0;
        fifo_empty = 1'b0;
        fifo_rdata = 24'h0;
        d          = 24'd1;
        test_reset();
        test_timing();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        @(negedge clk);
        @(negedge clk);
        mon_en = 0;
        n_checks++;
        if (sb_q.size() !== 0) begin
            n_fail++; $display("FAIL sb_drain got %0d entries exp 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
